// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, clock deglitch filter,
// 11-bit frame deframer with odd parity check, inter-edge timeout and a
// one-entry scancode buffer with ready/acknowledge/overrun handshake.
module ps2_frame_rx #(
    parameter int unsigned FILT = 8,
    parameter int unsigned TOUT = 7500
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       rx_ack,
    output logic       rx_ovr,
    output logic       rx_err,
    output logic       busy
);

    localparam logic [7:0]  FILT_M1 = 8'(FILT - 1);
    localparam logic [15:0] TOUT_M1 = 16'(TOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic       clk_s1, clk_s2;
    logic       dat_s1, dat_s2;
    logic [7:0] fcnt;
    logic       fclk, fclk_d;
    logic       fall;

    state_t      state, state_n;
    logic [2:0]  bitcnt, bitcnt_n;
    logic [7:0]  sh, sh_n;
    logic        pok, pok_n;
    logic [15:0] tcnt, tcnt_n;
    logic        commit;
    logic        err_n;

    // Two-flop synchronisers for both pins; reset to the idle bus level.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Clock filter: fclk follows the synchronised clock only after FILT
    // consecutive samples that disagree with the current filtered level.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            fcnt   <= '0;
            fclk   <= 1'b1;
            fclk_d <= 1'b1;
        end else begin
            fclk_d <= fclk;
            if (clk_s2 == fclk) begin
                fcnt <= '0;
            end else if (fcnt == FILT_M1) begin
                fclk <= clk_s2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 8'd1;
            end
        end
    end

    assign fall = fclk_d & ~fclk;

    // Frame state, shift register, parity flag and timeout counter.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state  <= IDLE;
            bitcnt <= '0;
            sh     <= '0;
            pok    <= 1'b0;
            tcnt   <= '0;
        end else begin
            state  <= state_n;
            bitcnt <= bitcnt_n;
            sh     <= sh_n;
            pok    <= pok_n;
            tcnt   <= tcnt_n;
        end
    end

    // Next-state logic: one outcome per fall; timeout overrides when no fall.
    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        sh_n     = sh;
        pok_n    = pok;
        tcnt_n   = tcnt + 16'd1;
        commit   = 1'b0;
        err_n    = 1'b0;

        unique case (state)
            IDLE: begin
                tcnt_n = '0;
                if (fall && !dat_s2) begin
                    state_n  = DATA;
                    bitcnt_n = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    sh_n = {dat_s2, sh[7:1]};
                    if (bitcnt == 3'd7) begin
                        state_n = PARITY;
                    end else begin
                        bitcnt_n = bitcnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    pok_n   = (^sh) ^ dat_s2;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    if (dat_s2 && pok) begin
                        commit = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (state != IDLE) begin
            if (fall) begin
                tcnt_n = '0;
            end else if (tcnt == TOUT_M1) begin
                err_n   = 1'b1;
                state_n = IDLE;
                tcnt_n  = '0;
            end
        end
    end

    // Receive buffer: a commit wins over a same-cycle acknowledge, and in that
    // case the overrun flag lands on its acknowledged (cleared) value.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_data <= '0;
            rx_rdy  <= 1'b0;
            rx_ovr  <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            rx_err <= err_n;
            if (commit) begin
                rx_data <= sh;
                rx_rdy  <= 1'b1;
                if (rx_rdy && !rx_ack) begin
                    rx_ovr <= 1'b1;
                end else if (rx_ack) begin
                    rx_ovr <= 1'b0;
                end
            end else if (rx_ack) begin
                rx_rdy <= 1'b0;
                rx_ovr <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: table of whole-frame vectors plus
// hand-written sequences for ack/commit collision, glitch, timeout and reset.
module tb_ps2_frame_rx;

    localparam int FILT = 8;
    localparam int TOUT = 200;
    localparam int H    = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_ack = 1'b0;
    logic       rx_ovr;
    logic       rx_err;
    logic       busy;

    ps2_frame_rx #(.FILT(FILT), .TOUT(TOUT)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_data  (rx_data),
        .rx_rdy   (rx_rdy),
        .rx_ack   (rx_ack),
        .rx_ovr   (rx_ovr),
        .rx_err   (rx_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int err_cnt = 0;
    int err_wide = 0;
    int busy_rises = 0;
    int last_fall = 0;
    logic err_prev = 1'b0;
    logic busy_prev = 1'b0;
    logic stop_phase = 1'b0;

    always @(posedge clk) cyc++;

    // Event monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_err) begin
            err_cnt++;
            if (err_prev) err_wide++;
        end
        err_prev = rx_err;
        if (busy && !busy_prev) busy_rises++;
        busy_prev = busy;
        if (dut.fall) last_fall = cyc;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive the first nbits of a frame; data changes mid-way through clock high.
    task automatic send_frame(input logic [7:0] b, input logic par_bad,
                              input logic stopv, input int nbits);
        logic [10:0] bits;
        bits = {stopv, (~^b) ^ par_bad, b, 1'b0};
        stop_phase = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            repeat (H / 2) @(negedge clk);
            ps2_data = bits[i];
            repeat (H / 2) @(negedge clk);
            if (i == 10) stop_phase = 1'b1;
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (H / 2) @(negedge clk);
        ps2_data = 1'b1;
        stop_phase = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 4 * H) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_idle"}, int'(busy), 0);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    typedef struct {
        logic [7:0] din;
        logic       par_bad;
        logic       stopv;
        logic       ack_after;
        logic       exp_rdy;
        logic [7:0] exp_data;
        logic       exp_ovr;
        int         exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int e0, b0, k, got;
        logic [7:0] d_at_fall;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b1, 8'h1C, 1'b0, 0};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h1C, 1'b0, 1};
        vecs[2] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hF0, 1'b0, 0};
        vecs[3] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 0};
        vecs[4] = '{8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1};
        vecs[5] = '{8'hE7, 1'b0, 1'b1, 1'b0, 1'b1, 8'hE7, 1'b0, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_data", int'(rx_data), 0);
        chk("rst_rdy", int'(rx_rdy), 0);
        chk("rst_ovr", int'(rx_ovr), 0);
        chk("rst_err", int'(rx_err), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (10) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            e0 = err_cnt;
            send_frame(vecs[v].din, vecs[v].par_bad, vecs[v].stopv, 11);
            wait_idle($sformatf("v%0d", v));
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_err", v), err_cnt - e0, vecs[v].exp_err);
            chk($sformatf("v%0d_rdy", v), int'(rx_rdy), int'(vecs[v].exp_rdy));
            chk($sformatf("v%0d_data", v), int'(rx_data), int'(vecs[v].exp_data));
            chk($sformatf("v%0d_ovr", v), int'(rx_ovr), int'(vecs[v].exp_ovr));
            if (vecs[v].ack_after) begin
                pulse_ack();
                chk($sformatf("v%0d_ack_rdy", v), int'(rx_rdy), 0);
                chk($sformatf("v%0d_ack_ovr", v), int'(rx_ovr), 0);
            end
        end

        // Ack coinciding with the commit of a second unacknowledged byte.
        got = 0;
        d_at_fall = 8'h00;
        fork
            send_frame(8'h5A, 1'b0, 1'b1, 11);
            begin
                k = 0;
                while (!stop_phase && k < 20 * H) begin
                    @(negedge clk);
                    k++;
                end
                k = 0;
                while (got == 0 && k < 4 * H) begin
                    @(negedge clk);
                    if (dut.fall) got = 1;
                    k++;
                end
                if (got == 1) begin
                    d_at_fall = rx_data;
                    rx_ack = 1'b1;
                    @(negedge clk);
                    rx_ack = 1'b0;
                end
            end
        join
        chk("coll_seen", got, 1);
        chk("coll_data_before", int'(d_at_fall), 'hE7);
        chk("coll_rdy", int'(rx_rdy), 1);
        chk("coll_ovr", int'(rx_ovr), 0);
        chk("coll_data", int'(rx_data), 'h5A);
        pulse_ack();
        chk("coll_ack_rdy", int'(rx_rdy), 0);

        // Short low glitch in idle must not start a frame.
        b0 = busy_rises;
        e0 = err_cnt;
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (H) @(negedge clk);
        chk("glitch_busy", busy_rises - b0, 0);
        send_frame(8'h29, 1'b0, 1'b1, 11);
        wait_idle("glitch");
        repeat (2) @(negedge clk);
        chk("glitch_rdy", int'(rx_rdy), 1);
        chk("glitch_data", int'(rx_data), 'h29);
        chk("glitch_err", err_cnt - e0, 0);
        pulse_ack();

        // Timeout: start + 4 data bits then the clock stalls high.
        // rx_err is registered, so it shows one cycle after the counter hits TOUT.
        e0 = err_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, 5);
        k = 0;
        while (!rx_err && k < TOUT + 100) begin
            @(negedge clk);
            k++;
        end
        chk("tout_delay", cyc - last_fall, TOUT + 1);
        repeat (3) @(negedge clk);
        chk("tout_err", err_cnt - e0, 1);
        chk("tout_busy", int'(busy), 0);
        chk("tout_rdy", int'(rx_rdy), 0);
        send_frame(8'h5A, 1'b0, 1'b1, 11);
        wait_idle("tout_next");
        repeat (2) @(negedge clk);
        chk("tout_next_rdy", int'(rx_rdy), 1);
        chk("tout_next_data", int'(rx_data), 'h5A);

        // Reset after 6 bits, with an unacknowledged byte held.
        e0 = err_cnt;
        send_frame(8'h12, 1'b0, 1'b1, 6);
        chk("mid_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_data", int'(rx_data), 0);
        chk("mrst_rdy", int'(rx_rdy), 0);
        chk("mrst_ovr", int'(rx_ovr), 0);
        chk("mrst_busy", int'(busy), 0);
        repeat (TOUT + 50) @(negedge clk);
        chk("mrst_err", err_cnt - e0, 0);
        send_frame(8'h76, 1'b0, 1'b1, 11);
        wait_idle("mrst_next");
        repeat (2) @(negedge clk);
        chk("mrst_next_rdy", int'(rx_rdy), 1);
        chk("mrst_next_data", int'(rx_data), 'h76);
        chk("mrst_next_ovr", int'(rx_ovr), 0);

        chk("err_width", err_wide, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
